// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction-fetch slice.
// Contents: NOP encoding, default reset PC, fetch FSM state encoding,
// the IF/ID output slot record and a PC increment helper.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        exc;
  } slot_t;

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle.
// Signals: req/addr from the fetch unit, ready/rdata back from memory.
// A response is valid in any cycle where ready=1 while req=1.
// Modports: master (fetch unit side), slave (memory side).
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_hold_buf.sv
// One-entry skid register for a fetch response that arrives while the
// IF/ID slot is stalled.
// Ports: clk, rst (async, active-high); load/unload/clear controls
// (clear has priority over load, load over unload); in_pc_plus4/in_instr
// captured on load; valid/pc_plus4/instr show the held entry.
module if_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_instr,
  output logic        valid,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr
);

  // Hold entry register with clear > load > unload priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      pc_plus4 <= 32'h0000_0000;
      instr    <= NOP_INSTR;
    end else if (clear) begin
      valid    <= 1'b0;
      pc_plus4 <= 32'h0000_0000;
      instr    <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      pc_plus4 <= in_pc_plus4;
      instr    <= in_instr;
    end else if (unload) begin
      valid    <= 1'b0;
      pc_plus4 <= pc_plus4;
      instr    <= NOP_INSTR;
    end else begin
      valid    <= valid;
      pc_plus4 <= pc_plus4;
      instr    <= instr;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues word fetches over imem (req/ready, wait states
// tolerated), applies branch/jump redirects and honours the IF/ID stall.
// Ports: clk, rst (async, active-high); stall; redirect_valid/redirect_pc;
// imem (master modport: req, addr, ready, rdata); if_valid, if_pc_plus4,
// if_instr (NOP whenever if_valid=0), if_exc.
// Build option: define IF_MISALIGN_EXC_EN to keep redirect_pc[1:0] and
// raise if_exc on a misaligned PC instead of fetching; otherwise the low
// PC bits are forced to 00 and if_exc stays 0.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  if_fetch_unit_if.master     imem,
  output logic                if_valid,
  output logic [31:0]         if_pc_plus4,
  output logic [31:0]         if_instr,
  output logic                if_exc
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  addr, addr_nxt;
  logic         req, req_nxt;
  slot_t        slot, slot_nxt;
  // boot delays the first fetch by one extra cycle after reset release.
  logic         boot, boot_nxt;
  // parked keeps S_IDLE sticky after a misaligned-PC exception.
  logic         parked, parked_nxt;

  logic         hold_load, hold_unload, hold_clear;
  logic         hold_valid;
  logic [31:0]  hold_pc_plus4, hold_instr;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         slot_free;

`ifdef IF_MISALIGN_EXC_EN
  assign target = redirect_pc;
`else
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign target = {redirect_pc[31:2], 2'b00};
`endif

  assign pc_inc    = next_word(pc);
  assign slot_free = !slot.valid || !stall;

  if_hold_buf u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (hold_load),
    .unload      (hold_unload),
    .clear       (hold_clear),
    .in_pc_plus4 (pc_inc),
    .in_instr    (imem.rdata),
    .valid       (hold_valid),
    .pc_plus4    (hold_pc_plus4),
    .instr       (hold_instr)
  );

  // State, PC, request and output-slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      addr   <= RESET_PC;
      req    <= 1'b0;
      slot   <= '0;
      boot   <= 1'b1;
      parked <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr   <= addr_nxt;
      req    <= req_nxt;
      slot   <= slot_nxt;
      boot   <= boot_nxt;
      parked <= parked_nxt;
    end
  end

  // Next-state, PC, slot and hold-buffer control.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    slot_nxt    = slot;
    boot_nxt    = boot;
    parked_nxt  = parked;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    hold_clear  = 1'b0;

    // A consumed slot empties unless refilled below.
    if (slot.valid && !stall) begin
      slot_nxt.valid = 1'b0;
      slot_nxt.instr = NOP_INSTR;
      slot_nxt.exc   = 1'b0;
    end else begin
      slot_nxt = slot;
    end

    if (redirect_valid) begin
      pc_nxt         = target;
      slot_nxt.valid = 1'b0;
      slot_nxt.instr = NOP_INSTR;
      slot_nxt.exc   = 1'b0;
      hold_clear     = 1'b1;
      boot_nxt       = 1'b0;
      parked_nxt     = 1'b0;
      case (state)
        // An in-flight request must still complete before refetching.
        S_FETCH: begin
          if (req && !imem.ready) state_nxt = S_DRAIN;
          else                    state_nxt = S_FETCH;
        end
        S_DRAIN: begin
          if (imem.ready) state_nxt = S_FETCH;
          else            state_nxt = S_DRAIN;
        end
        default: state_nxt = S_FETCH;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          boot_nxt = 1'b0;
          if (!boot && !parked) state_nxt = S_FETCH;
          else                  state_nxt = S_IDLE;
        end
        S_FETCH: begin
`ifdef IF_MISALIGN_EXC_EN
          if (pc[1:0] != 2'b00) begin
            if (slot_free) begin
              slot_nxt.valid    = 1'b1;
              slot_nxt.pc_plus4 = pc_inc;
              slot_nxt.instr    = NOP_INSTR;
              slot_nxt.exc      = 1'b1;
              parked_nxt        = 1'b1;
              state_nxt         = S_IDLE;
            end else begin
              state_nxt = S_FETCH;
            end
          end else
`endif
          if (imem.ready) begin
            pc_nxt = pc_inc;
            if (slot_free) begin
              slot_nxt.valid    = 1'b1;
              slot_nxt.pc_plus4 = pc_inc;
              slot_nxt.instr    = imem.rdata;
              slot_nxt.exc      = 1'b0;
              state_nxt         = S_FETCH;
            end else begin
              hold_load = 1'b1;
              state_nxt = S_HOLD;
            end
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_HOLD: begin
          if (!stall && hold_valid) begin
            slot_nxt.valid    = 1'b1;
            slot_nxt.pc_plus4 = hold_pc_plus4;
            slot_nxt.instr    = hold_instr;
            slot_nxt.exc      = 1'b0;
            hold_unload       = 1'b1;
            state_nxt         = S_FETCH;
          end else begin
            state_nxt = S_HOLD;
          end
        end
        S_DRAIN: begin
          if (imem.ready) state_nxt = S_FETCH;
          else            state_nxt = S_DRAIN;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered request: S_DRAIN keeps the old address until it completes.
  always_comb begin
    req_nxt = (state_nxt == S_FETCH) || (state_nxt == S_DRAIN);
`ifdef IF_MISALIGN_EXC_EN
    if ((state_nxt == S_FETCH) && (pc_nxt[1:0] != 2'b00)) req_nxt = 1'b0;
    else                                                  req_nxt = req_nxt;
`endif
    if (state_nxt == S_DRAIN) addr_nxt = addr;
    else                      addr_nxt = pc_nxt;
  end

  assign imem.req    = req;
  assign imem.addr   = addr;
  assign if_valid    = slot.valid;
  assign if_pc_plus4 = slot.pc_plus4;
  assign if_instr    = slot.instr;
  assign if_exc      = slot.exc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Memory returns
// rdata = addr ^ 32'h1300_0000 combinationally; ready is driven per test.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_exc;
  int          cmps = 0;
  int          errs = 0;

  if_fetch_unit_if imem ();

  assign imem.rdata = imem.addr ^ 32'h1300_0000;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_3000), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem.master),
    .if_valid       (if_valid),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .if_exc         (if_exc)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, release, then run to the first delivered slot (3000 fetched, addr 3004).
  task automatic boot_stream();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem.ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem.ready = 1'b0;
    tick(); tick();
    if (imem.req !== 1'b0) begin $display("FAIL rst_req: got %0h want 0", imem.req); errs++; end cmps++;
    if (if_valid !== 1'b0) begin $display("FAIL rst_valid: got %0h want 0", if_valid); errs++; end cmps++;
    if (if_pc_plus4 !== 32'h0) begin $display("FAIL rst_pc4: got %h want 0", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'h0) begin $display("FAIL rst_instr: got %h want 0", if_instr); errs++; end cmps++;
    if (if_exc !== 1'b0) begin $display("FAIL rst_exc: got %0h want 0", if_exc); errs++; end cmps++;
  endtask

  task automatic test_zero_wait();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem.ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    if (imem.req !== 1'b0) begin $display("FAIL zw_idle_req: got %0h want 0", imem.req); errs++; end cmps++;
    tick();
    if (imem.req !== 1'b1) begin $display("FAIL zw_req: got %0h want 1", imem.req); errs++; end cmps++;
    if (imem.addr !== 32'h3000) begin $display("FAIL zw_first_addr: got %h want 00003000", imem.addr); errs++; end cmps++;
    if (if_valid !== 1'b0) begin $display("FAIL zw_valid_early: got %0h want 0", if_valid); errs++; end cmps++;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (if_valid !== 1'b1) begin $display("FAIL zw_valid[%0d]: got %0h want 1", k, if_valid); errs++; end cmps++;
      if (if_pc_plus4 !== 32'h3004 + 32'(4 * k)) begin
        $display("FAIL zw_pc4[%0d]: got %h want %h", k, if_pc_plus4, 32'h3004 + 32'(4 * k)); errs++;
      end cmps++;
      if (if_instr !== ((32'h3000 + 32'(4 * k)) ^ 32'h1300_0000)) begin
        $display("FAIL zw_instr[%0d]: got %h want %h", k, if_instr, (32'h3000 + 32'(4 * k)) ^ 32'h1300_0000); errs++;
      end cmps++;
      if (if_exc !== 1'b0) begin $display("FAIL zw_exc[%0d]: got %0h want 0", k, if_exc); errs++; end cmps++;
    end
  endtask

  task automatic test_wait_state();
    boot_stream();
    imem.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (imem.addr !== 32'h3004) begin $display("FAIL ws_addr[%0d]: got %h want 00003004", k, imem.addr); errs++; end cmps++;
      if (imem.req !== 1'b1) begin $display("FAIL ws_req[%0d]: got %0h want 1", k, imem.req); errs++; end cmps++;
      if (if_valid !== 1'b0) begin $display("FAIL ws_valid[%0d]: got %0h want 0", k, if_valid); errs++; end cmps++;
      if (if_instr !== 32'h0) begin $display("FAIL ws_nop[%0d]: got %h want 0", k, if_instr); errs++; end cmps++;
    end
    imem.ready = 1'b1;
    tick();
    if (if_valid !== 1'b1) begin $display("FAIL ws_deliver_valid: got %0h want 1", if_valid); errs++; end cmps++;
    if (if_pc_plus4 !== 32'h3008) begin $display("FAIL ws_deliver_pc4: got %h want 00003008", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'h1300_3004) begin $display("FAIL ws_deliver_instr: got %h want 13003004", if_instr); errs++; end cmps++;
    if (imem.addr !== 32'h3008) begin $display("FAIL ws_next_addr: got %h want 00003008", imem.addr); errs++; end cmps++;
    imem.ready = 1'b0;
    tick();
    if (if_valid !== 1'b0) begin $display("FAIL ws_once: got %0h want 0", if_valid); errs++; end cmps++;
  endtask

  task automatic test_stall_hold();
    boot_stream();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (if_valid !== 1'b1) begin $display("FAIL st_valid[%0d]: got %0h want 1", k, if_valid); errs++; end cmps++;
      if (if_pc_plus4 !== 32'h3004) begin $display("FAIL st_pc4[%0d]: got %h want 00003004", k, if_pc_plus4); errs++; end cmps++;
      if (if_instr !== 32'h1300_3000) begin $display("FAIL st_instr[%0d]: got %h want 13003000", k, if_instr); errs++; end cmps++;
      if (imem.req !== 1'b0) begin $display("FAIL st_hold_req[%0d]: got %0h want 0", k, imem.req); errs++; end cmps++;
    end
    stall = 1'b0;
    tick();
    if (if_pc_plus4 !== 32'h3008) begin $display("FAIL st_b_pc4: got %h want 00003008", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'h1300_3004) begin $display("FAIL st_b_instr: got %h want 13003004", if_instr); errs++; end cmps++;
    if (imem.req !== 1'b1) begin $display("FAIL st_resume_req: got %0h want 1", imem.req); errs++; end cmps++;
    if (imem.addr !== 32'h3008) begin $display("FAIL st_resume_addr: got %h want 00003008", imem.addr); errs++; end cmps++;
    tick();
    if (if_pc_plus4 !== 32'h300C) begin $display("FAIL st_c_pc4: got %h want 0000300c", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'h1300_3008) begin $display("FAIL st_c_instr: got %h want 13003008", if_instr); errs++; end cmps++;
  endtask

  task automatic test_redirect_outstanding();
    boot_stream();
    imem.ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick();
    redirect_valid = 1'b0;
    if (if_valid !== 1'b0) begin $display("FAIL ro_valid: got %0h want 0", if_valid); errs++; end cmps++;
    if (if_instr !== 32'h0) begin $display("FAIL ro_instr: got %h want 0", if_instr); errs++; end cmps++;
    if (imem.addr !== 32'h3004) begin $display("FAIL ro_drain_addr: got %h want 00003004", imem.addr); errs++; end cmps++;
    imem.ready = 1'b1;
    tick();
    if (if_valid !== 1'b0) begin $display("FAIL ro_dropped: got %0h want 0", if_valid); errs++; end cmps++;
    if (imem.addr !== 32'h4000) begin $display("FAIL ro_new_addr: got %h want 00004000", imem.addr); errs++; end cmps++;
    tick();
    if (if_pc_plus4 !== 32'h4004) begin $display("FAIL ro_pc4: got %h want 00004004", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'h1300_4000) begin $display("FAIL ro_instr_new: got %h want 13004000", if_instr); errs++; end cmps++;
  endtask

  task automatic test_redirect_stall_ready();
    boot_stream();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000; imem.ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    if (if_valid !== 1'b0) begin $display("FAIL rs_valid: got %0h want 0", if_valid); errs++; end cmps++;
    if (if_instr !== 32'h0) begin $display("FAIL rs_instr: got %h want 0", if_instr); errs++; end cmps++;
    if (imem.addr !== 32'h4000) begin $display("FAIL rs_addr: got %h want 00004000", imem.addr); errs++; end cmps++;
    if (imem.req !== 1'b1) begin $display("FAIL rs_req: got %0h want 1", imem.req); errs++; end cmps++;
    tick();
    if (if_pc_plus4 !== 32'h4004) begin $display("FAIL rs_pc4: got %h want 00004004", if_pc_plus4); errs++; end cmps++;
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    boot_stream();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    if (imem.addr !== 32'hFFFF_FFFC) begin $display("FAIL wr_addr: got %h want fffffffc", imem.addr); errs++; end cmps++;
    tick();
    if (if_pc_plus4 !== 32'h0) begin $display("FAIL wr_pc4: got %h want 00000000", if_pc_plus4); errs++; end cmps++;
    if (if_instr !== 32'hECFF_FFFC) begin $display("FAIL wr_instr: got %h want ecfffffc", if_instr); errs++; end cmps++;
    if (imem.addr !== 32'h0) begin $display("FAIL wr_next_addr: got %h want 00000000", imem.addr); errs++; end cmps++;
  endtask

  task automatic test_reset_mid_request();
    boot_stream();
    imem.ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    if (imem.req !== 1'b0) begin $display("FAIL mr_req: got %0h want 0", imem.req); errs++; end cmps++;
    if (imem.addr !== 32'h3000) begin $display("FAIL mr_addr: got %h want 00003000", imem.addr); errs++; end cmps++;
    if (if_valid !== 1'b0) begin $display("FAIL mr_valid: got %0h want 0", if_valid); errs++; end cmps++;
    imem.ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    if (if_valid !== 1'b0) begin $display("FAIL mr_late_ready: got %0h want 0", if_valid); errs++; end cmps++;
  endtask

  task automatic test_misalign();
    boot_stream();
    redirect_valid = 1'b1; redirect_pc = 32'h4002;
    tick();
    redirect_valid = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
    if (imem.req !== 1'b0) begin $display("FAIL ma_req: got %0h want 0", imem.req); errs++; end cmps++;
    tick();
    if (if_valid !== 1'b1) begin $display("FAIL ma_valid: got %0h want 1", if_valid); errs++; end cmps++;
    if (if_exc !== 1'b1) begin $display("FAIL ma_exc: got %0h want 1", if_exc); errs++; end cmps++;
    if (if_instr !== 32'h0) begin $display("FAIL ma_instr: got %h want 0", if_instr); errs++; end cmps++;
    if (if_pc_plus4 !== 32'h4006) begin $display("FAIL ma_pc4: got %h want 00004006", if_pc_plus4); errs++; end cmps++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (imem.req !== 1'b0) begin $display("FAIL ma_parked_req[%0d]: got %0h want 0", k, imem.req); errs++; end cmps++;
    end
    if (if_exc !== 1'b0) begin $display("FAIL ma_exc_clear: got %0h want 0", if_exc); errs++; end cmps++;
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    tick();
    redirect_valid = 1'b0;
    if (imem.req !== 1'b1) begin $display("FAIL ma_resume_req: got %0h want 1", imem.req); errs++; end cmps++;
    if (imem.addr !== 32'h5000) begin $display("FAIL ma_resume_addr: got %h want 00005000", imem.addr); errs++; end cmps++;
`else
    if (imem.addr !== 32'h4000) begin $display("FAIL al_addr: got %h want 00004000", imem.addr); errs++; end cmps++;
    tick();
    if (if_pc_plus4 !== 32'h4004) begin $display("FAIL al_pc4: got %h want 00004004", if_pc_plus4); errs++; end cmps++;
    if (if_exc !== 1'b0) begin $display("FAIL al_exc: got %0h want 0", if_exc); errs++; end cmps++;
`endif
  endtask

  initial begin
    imem.ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_stall_hold();
    test_redirect_outstanding();
    test_redirect_stall_ready();
    test_wrap();
    test_reset_mid_request();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
